address_counter: RTL and testbench

- Free-running BRAM address generator for triggered capture: a COUNT_WIDTH-bit word counter, presented as a 32-bit byte address, sweeps the buffer continuously.
- A rising edge on trig arms a capture. At the next counter wrap, write enables assert for exactly one full sweep, so a buffer is always written from address 0 to the last word.
- Sits between the ADC sample stream and a 32-bit-wide BRAM port.

---
 rtl/address_counter.sv | 61 ++++++
 tb/tb_address_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/address_counter.sv
// address_counter: free-running BRAM address generator for triggered capture.
// A COUNT_WIDTH-bit word counter sweeps the buffer on every enabled cycle.
// A rising edge on trig arms one capture. Writes start at the next wrap and
// last for exactly one full sweep, so the buffer always fills from word 0.
module address_counter #(
  parameter int COUNT_WIDTH = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        trig,
  output logic [31:0] address,
  output logic [3:0]  wen
);

  localparam logic [COUNT_WIDTH-1:0] MAX = {COUNT_WIDTH{1'b1}};

  logic [COUNT_WIDTH-1:0] count;
  logic                   wen_reg;
  logic                   armed;
  logic                   trig_d;
  logic                   rise;
  logic                   sweep_start;

  // trig is sampled every cycle, independent of clken, so short pulses
  // during a stall are not lost.
  assign rise        = trig & ~trig_d;
  assign sweep_start = clken & (count == MAX);

  // trig_d resets high so a trig held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) trig_d <= 1'b1;
    else     trig_d <= trig;
  end

  // Word counter: advances on enabled cycles, wraps naturally at MAX.
  always_ff @(posedge clk) begin
    if (rst)        count <= '0;
    else if (clken) count <= count + 1'b1;
  end

  // Arm/sweep control: at a wrap the pending arm (or a same-cycle edge) is
  // turned into a full sweep; otherwise wen_reg drops, ending any sweep.
  // An edge at the wrap cycle is absorbed rather than queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_reg <= 1'b0;
      armed   <= 1'b0;
    end else if (sweep_start) begin
      wen_reg <= armed | rise;
      armed   <= 1'b0;
    end else if (rise) begin
      armed   <= 1'b1;
    end
  end

  // Byte address of the current word; stalled cycles never write.
  assign address = {{(32-COUNT_WIDTH){1'b0}}, count} << 2;
  assign wen     = {4{wen_reg & clken}};

endmodule

// File: tb/tb_address_counter.sv
// tb_address_counter: directed scenarios plus randomized traffic, every
// cycle compared against a capture-level reference model.
module tb_address_counter;

  localparam int CW    = 5;
  localparam int DEPTH = 1 << CW;

  logic        clk = 1'b0;
  logic        rst, clken, trig;
  logic [31:0] address;
  logic [3:0]  wen;

  address_counter #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .clken(clken), .trig(trig),
    .address(address), .wen(wen)
  );

  always #4 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: word position, a pending-capture flag and the number
  // of writes still owed by the current capture
  int m_pos;
  bit m_pending;
  int m_owed;
  bit m_prev_trig;

  // observation bookkeeping for directed scenarios
  int nwr, cur_run, max_run, dups;
  bit seen [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_obs();
    nwr = 0; cur_run = 0; max_run = 0; dups = 0;
    for (int i = 0; i < DEPTH; i++) seen[i] = 1'b0;
  endtask

  task automatic step(input logic t, input logic ce, input logic r);
    bit edge_seen;
    logic [3:0] exp_wen;
    trig = t; clken = ce; rst = r;
    @(posedge clk);
    if (r) begin
      m_pos = 0; m_pending = 0; m_owed = 0; m_prev_trig = 1;
    end else begin
      edge_seen   = t && !m_prev_trig;
      m_prev_trig = t;
      if (ce) begin
        if (m_owed > 0) m_owed--;
        if (m_pos == DEPTH - 1) begin
          // wrap: a queued or simultaneous trigger buys one full buffer
          m_owed    = (m_pending || edge_seen) ? DEPTH : 0;
          m_pending = 0;
        end else if (edge_seen) m_pending = 1;
        m_pos = (m_pos + 1) % DEPTH;
      end else if (edge_seen) m_pending = 1;
    end
    #1;
    exp_wen = (m_owed > 0 && ce) ? 4'hF : 4'h0;
    chk("addr", address, 32'(m_pos * 4));
    chk("wen", {28'd0, wen}, {28'd0, exp_wen});
    if (wen != 4'h0) begin
      nwr++; cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      if (seen[address[CW+1:2]]) dups++;
      seen[address[CW+1:2]] = 1'b1;
    end else if (ce) cur_run = 0;
  endtask

  task automatic goto_pos(input int c);
    int k = 0;
    while (m_pos != c && k < 4 * DEPTH) begin
      step(0, 1, 0); k++;
    end
    if (m_pos != c) chk("goto_timeout", 32'(m_pos), 32'(c));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0);
  endtask

  initial begin
    // reset with trig held high: no edge may be registered on release
    step(1, 1, 1);
    step(1, 1, 1);
    chk("rst_addr", address, 32'd0);
    chk("rst_wen", {28'd0, wen}, 32'd0);
    clear_obs();
    for (int i = 0; i < 40; i++) step(1, 1, 0);
    chk("trig_through_rst_writes", 32'(nwr), 32'd0);

    // idle sweep
    clear_obs();
    idle(100);
    chk("idle_writes", 32'(nwr), 32'd0);

    // single trigger at count 10
    goto_pos(10);
    clear_obs();
    step(1, 1, 0);
    idle(100);
    chk("single_writes", 32'(nwr), 32'(DEPTH));
    chk("single_run", 32'(max_run), 32'(DEPTH));
    chk("single_dups", 32'(dups), 32'd0);

    // level held high: only the edge counts
    clear_obs();
    for (int i = 0; i < 200; i++) step(1, 1, 0);
    idle(10);
    chk("level_writes", 32'(nwr), 32'(DEPTH));

    // back-to-back: second edge mid-sweep chains the next sweep
    goto_pos(5);
    clear_obs();
    step(1, 1, 0);
    goto_pos(0);
    goto_pos(20);
    step(1, 1, 0);
    idle(120);
    chk("b2b_writes", 32'(nwr), 32'(2 * DEPTH));
    chk("b2b_run", 32'(max_run), 32'(2 * DEPTH));

    // edge exactly at the wrap cycle is absorbed
    goto_pos(DEPTH - 1);
    clear_obs();
    step(1, 1, 0);
    idle(100);
    chk("wrap_writes", 32'(nwr), 32'(DEPTH));

    // 3-cycle stall mid-sweep
    goto_pos(5);
    clear_obs();
    step(1, 1, 0);
    goto_pos(0);
    goto_pos(12);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    idle(100);
    chk("stall_writes", 32'(nwr), 32'(DEPTH));
    chk("stall_dups", 32'(dups), 32'd0);

    // reset mid-sweep with a pending arm queued
    goto_pos(3);
    step(1, 1, 0);
    goto_pos(0);
    goto_pos(10);
    step(0, 1, 0);
    step(1, 1, 0);
    goto_pos(15);
    step(0, 1, 1);
    chk("midrst_wen", {28'd0, wen}, 32'd0);
    chk("midrst_addr", address, 32'd0);
    clear_obs();
    idle(100);
    chk("post_rst_writes", 32'(nwr), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 9) < 2, $urandom_range(0, 9) != 0,
           $urandom_range(0, 299) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
